easy_fifo_axis_pkt: RTL and testbench

EASY_FIFO_AXIS_PKT -- requirements
Module: easy_fifo_axis_pkt

---
 rtl/easy_fifo_pkg.sv | 14 +
 rtl/easy_fifo_axis_pkt_if.sv | 15 +
 rtl/easy_fifo_ram.sv | 22 ++
 rtl/easy_fifo_axis_pkt.sv | 115 +++++++++++
 tb/tb_easy_fifo_axis_pkt.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/easy_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
package easy_fifo_pkg;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } fifo_state_e;

    // One extra bit above the address width so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/easy_fifo_axis_pkt_if.sv
// AXI-Stream beat bundle; master drives data/valid, slave drives ready.
interface easy_fifo_axis_pkt_if #(
    parameter int DWIDTH     = 32,
    parameter int USER_WIDTH = 1
);
    logic [DWIDTH-1:0]     tdata;
    logic [DWIDTH/8-1:0]   tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/easy_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module easy_fifo_ram
    import easy_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-2:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-2:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/easy_fifo_axis_pkt.sv
// AXI-Stream FIFO with store-and-forward packet commit, oversize-packet drop
// and first-word fall-through output.
module easy_fifo_axis_pkt
    import easy_fifo_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int DEPTH      = 16,
    parameter int PKT_MODE   = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    easy_fifo_axis_pkt_if.slave     s_axis,
    easy_fifo_axis_pkt_if.master    m_axis,
    output logic [ptr_w(DEPTH)-1:0] fill,
    output logic [ptr_w(DEPTH)-1:0] pkt_count,
    output logic                    drop_pulse
);
    localparam int PW = ptr_w(DEPTH);
    localparam int KW = DWIDTH / 8;
    localparam int WW = DWIDTH + KW + 1 + USER_WIDTH;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam bit PKT = (PKT_MODE != 0);

    fifo_state_e   state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_commit, rd_ptr, pkt_cnt_r, pending;
    logic          ready_en, drop_r;
    logic          s_ready, wr_en, m_valid, m_hs, m_last;
    logic          drop_start, drop_end, cnt_inc, cnt_dec;
    logic [WW-1:0] wr_word, rd_word;

    assign fill    = wr_ptr - rd_ptr;
    assign pending = wr_ptr - wr_commit;
    assign m_valid = (rd_ptr != wr_commit);
    assign m_last  = rd_word[DWIDTH+KW];
    assign m_hs    = m_valid && m_axis.tready;
    assign cnt_inc = wr_en && s_axis.tlast;
    assign cnt_dec = m_hs && m_last;

    assign wr_word = {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    assign {m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = rd_word;
    assign m_axis.tvalid = m_valid;
    assign s_axis.tready = s_ready;
    assign pkt_count     = pkt_cnt_r;
    assign drop_pulse    = drop_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACCEPT;
        else        state <= state_nxt;
    end

    // A packet that alone fills the whole FIFO can never commit, so it is sunk.
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        wr_en      = 1'b0;
        drop_start = 1'b0;
        drop_end   = 1'b0;
        case (state)
            ST_ACCEPT: begin
                if (PKT && pending == DEPTH_P) begin
                    drop_start = 1'b1;
                    state_nxt  = ST_DROP;
                end else begin
                    s_ready = ready_en && (fill < DEPTH_P);
                    wr_en   = s_axis.tvalid && s_ready;
                end
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    drop_end  = 1'b1;
                    state_nxt = ST_ACCEPT;
                end
            end
            default: state_nxt = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            drop_r    <= 1'b0;
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
            pkt_cnt_r <= '0;
        end else begin
            ready_en <= 1'b1;
            drop_r   <= drop_end;
            if (drop_start)  wr_ptr <= wr_commit;
            else if (wr_en)  wr_ptr <= wr_ptr + ONE_P;
            if (wr_en && (!PKT || s_axis.tlast)) wr_commit <= wr_ptr + ONE_P;
            if (m_hs) rd_ptr <= rd_ptr + ONE_P;
            case ({cnt_inc, cnt_dec})
                2'b10:   pkt_cnt_r <= pkt_cnt_r + ONE_P;
                2'b01:   pkt_cnt_r <= pkt_cnt_r - ONE_P;
                default: pkt_cnt_r <= pkt_cnt_r;
            endcase
        end
    end

    easy_fifo_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[PW-2:0]),
        .wdata (wr_word),
        .raddr (rd_ptr[PW-2:0]),
        .rdata (rd_word)
    );
endmodule

// File: tb/tb_easy_fifo_axis_pkt.sv
// Directed bench: dut1 is store-and-forward (DEPTH 16), dut0 is cut-through.
module tb_easy_fifo_axis_pkt;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    easy_fifo_axis_pkt_if #(.DWIDTH(32), .USER_WIDTH(1)) s1 ();
    easy_fifo_axis_pkt_if #(.DWIDTH(32), .USER_WIDTH(1)) m1 ();
    easy_fifo_axis_pkt_if #(.DWIDTH(32), .USER_WIDTH(1)) s0 ();
    easy_fifo_axis_pkt_if #(.DWIDTH(32), .USER_WIDTH(1)) m0 ();

    logic [4:0] fill1, pc1, fill0, pc0;
    logic       dp1, dp0;
    int errors = 0;
    int checks = 0;
    int drop_cnt = 0;

    easy_fifo_axis_pkt #(.DWIDTH(32), .DEPTH(16), .PKT_MODE(1), .USER_WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1),
        .fill(fill1), .pkt_count(pc1), .drop_pulse(dp1));

    easy_fifo_axis_pkt #(.DWIDTH(32), .DEPTH(16), .PKT_MODE(0), .USER_WIDTH(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0),
        .fill(fill0), .pkt_count(pc0), .drop_pulse(dp0));

    always @(negedge clk) if (dp1) drop_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s1.tdata = '0; s1.tkeep = '0; s1.tlast = 1'b0; s1.tuser = '0; s1.tvalid = 1'b0;
        s0.tdata = '0; s0.tkeep = '0; s0.tlast = 1'b0; s0.tuser = '0; s0.tvalid = 1'b0;
        m1.tready = 1'b0;
        m0.tready = 1'b0;
    endtask

    task automatic drive1(input logic [31:0] d, input logic [3:0] k, input logic last, input logic user);
        s1.tdata = d; s1.tkeep = k; s1.tlast = last; s1.tuser = user; s1.tvalid = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (m1.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m1.tvalid); end
        checks++; if (s1.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s1.tready); end
        checks++; if (fill1 !== 5'd0) begin errors++; $display("FAIL rst_fill: got %0d want 0", fill1); end
        checks++; if (pc1 !== 5'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d want 0", pc1); end
        checks++; if (dp1 !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b want 0", dp1); end
        rst_n = 1'b1;
        tick();
        checks++; if (s1.tready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b want 1", s1.tready); end
        checks++; if (s0.tready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise0: got %b want 1", s0.tready); end
    endtask

    task automatic test_pkt4();
        m1.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive1(32'h1000 + i, (i == 3) ? 4'h3 : 4'hF, i == 3, 1'(i & 1));
            checks++; if (m1.tvalid !== 1'b0) begin errors++; $display("FAIL pkt4_early_valid beat %0d: got %b want 0", i, m1.tvalid); end
            checks++; if (pc1 !== 5'd0) begin errors++; $display("FAIL pkt4_cnt0 beat %0d: got %0d want 0", i, pc1); end
            tick();
        end
        s1.tvalid = 1'b0;
        checks++; if (pc1 !== 5'd1) begin errors++; $display("FAIL pkt4_cnt1: got %0d want 1", pc1); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (m1.tvalid !== 1'b1) begin errors++; $display("FAIL pkt4_valid beat %0d: got %b want 1", j, m1.tvalid); end
            checks++; if (m1.tdata !== 32'h1000 + j) begin errors++; $display("FAIL pkt4_data beat %0d: got %h want %h", j, m1.tdata, 32'h1000 + j); end
            checks++; if (m1.tlast !== (j == 3)) begin errors++; $display("FAIL pkt4_last beat %0d: got %b want %b", j, m1.tlast, j == 3); end
            checks++; if (m1.tuser !== 1'(j & 1)) begin errors++; $display("FAIL pkt4_user beat %0d: got %b want %b", j, m1.tuser, 1'(j & 1)); end
            checks++; if (m1.tkeep !== ((j == 3) ? 4'h3 : 4'hF)) begin errors++; $display("FAIL pkt4_keep beat %0d: got %h", j, m1.tkeep); end
            tick();
        end
        checks++; if (m1.tvalid !== 1'b0) begin errors++; $display("FAIL pkt4_drained: got %b want 0", m1.tvalid); end
        checks++; if (pc1 !== 5'd0) begin errors++; $display("FAIL pkt4_cnt_end: got %0d want 0", pc1); end
        m1.tready = 1'b0;
    endtask

    task automatic test_cut_through();
        s0.tdata = 32'hA5A5A5A5; s0.tkeep = 4'hF; s0.tlast = 1'b1; s0.tuser = 1'b0; s0.tvalid = 1'b1;
        m0.tready = 1'b0;
        checks++; if (m0.tvalid !== 1'b0) begin errors++; $display("FAIL ct_idle_valid: got %b want 0", m0.tvalid); end
        tick();
        s0.tvalid = 1'b0;
        checks++; if (m0.tvalid !== 1'b1) begin errors++; $display("FAIL ct_valid: got %b want 1", m0.tvalid); end
        checks++; if (m0.tdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL ct_data: got %h want a5a5a5a5", m0.tdata); end
        checks++; if (fill0 !== 5'd1) begin errors++; $display("FAIL ct_fill1: got %0d want 1", fill0); end
        m0.tready = 1'b1;
        tick();
        m0.tready = 1'b0;
        checks++; if (fill0 !== 5'd0) begin errors++; $display("FAIL ct_fill0: got %0d want 0", fill0); end
        checks++; if (m0.tvalid !== 1'b0) begin errors++; $display("FAIL ct_empty: got %b want 0", m0.tvalid); end
        checks++; if (dp0 !== 1'b0) begin errors++; $display("FAIL ct_drop: got %b want 0", dp0); end
    endtask

    task automatic test_exact_depth_full();
        int d0;
        d0 = drop_cnt;
        m1.tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive1(32'h2000 + i, 4'hF, i == 15, 1'b0);
            checks++; if (s1.tready !== 1'b1) begin errors++; $display("FAIL full16_ready beat %0d: got %b want 1", i, s1.tready); end
            tick();
        end
        s1.tvalid = 1'b0;
        checks++; if (fill1 !== 5'd16) begin errors++; $display("FAIL full16_fill: got %0d want 16", fill1); end
        checks++; if (pc1 !== 5'd1) begin errors++; $display("FAIL full16_cnt: got %0d want 1", pc1); end
        checks++; if (s1.tready !== 1'b0) begin errors++; $display("FAIL full16_not_ready: got %b want 0", s1.tready); end
        drive1(32'h3000, 4'hF, 1'b1, 1'b0);
        m1.tready = 1'b1;
        checks++; if (m1.tdata !== 32'h2000) begin errors++; $display("FAIL full16_head: got %h want 2000", m1.tdata); end
        tick();
        s1.tvalid = 1'b0;
        m1.tready = 1'b0;
        checks++; if (fill1 !== 5'd15) begin errors++; $display("FAIL simul_fill: got %0d want 15", fill1); end
        checks++; if (s1.tready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %b want 1", s1.tready); end
        checks++; if (pc1 !== 5'd1) begin errors++; $display("FAIL simul_cnt: got %0d want 1", pc1); end
        m1.tready = 1'b1;
        for (int j = 1; j < 16; j++) begin
            checks++; if (m1.tdata !== 32'h2000 + j) begin errors++; $display("FAIL full16_data beat %0d: got %h want %h", j, m1.tdata, 32'h2000 + j); end
            checks++; if (m1.tlast !== (j == 15)) begin errors++; $display("FAIL full16_last beat %0d: got %b", j, m1.tlast); end
            tick();
        end
        m1.tready = 1'b0;
        checks++; if (fill1 !== 5'd0) begin errors++; $display("FAIL full16_drained: got %0d want 0", fill1); end
        checks++; if (pc1 !== 5'd0) begin errors++; $display("FAIL full16_cnt_end: got %0d want 0", pc1); end
        checks++; if (drop_cnt !== d0) begin errors++; $display("FAIL full16_no_drop: got %0d pulses want 0", drop_cnt - d0); end
    endtask

    task automatic test_oversize_drop();
        int d0;
        int stall;
        d0 = drop_cnt;
        stall = 0;
        m1.tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive1(32'h4000 + i, 4'hF, i == 19, 1'b0);
            for (int w = 0; w < 8 && !s1.tready; w++) begin
                tick();
                stall++;
            end
            tick();
            if (i == 15) begin
                checks++; if (fill1 !== 5'd16) begin errors++; $display("FAIL drop_fill16: got %0d want 16", fill1); end
            end
        end
        s1.tvalid = 1'b0;
        checks++; if (stall !== 1) begin errors++; $display("FAIL drop_stall: got %0d cycles want 1", stall); end
        checks++; if (dp1 !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", dp1); end
        checks++; if (fill1 !== 5'd0) begin errors++; $display("FAIL drop_fill: got %0d want 0", fill1); end
        checks++; if (m1.tvalid !== 1'b0) begin errors++; $display("FAIL drop_no_output: got %b want 0", m1.tvalid); end
        checks++; if (pc1 !== 5'd0) begin errors++; $display("FAIL drop_cnt: got %0d want 0", pc1); end
        tick();
        checks++; if (dp1 !== 1'b0) begin errors++; $display("FAIL drop_pulse_clear: got %b want 0", dp1); end
        checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL drop_pulse_len: got %0d want 1", drop_cnt - d0); end
        drive1(32'h7000, 4'hF, 1'b1, 1'b1);
        tick();
        s1.tvalid = 1'b0;
        checks++; if (m1.tvalid !== 1'b1 || m1.tdata !== 32'h7000) begin errors++; $display("FAIL post_drop_pkt: got %b/%h want 1/7000", m1.tvalid, m1.tdata); end
        m1.tready = 1'b1;
        tick();
        m1.tready = 1'b0;
        checks++; if (fill1 !== 5'd0) begin errors++; $display("FAIL post_drop_fill: got %0d want 0", fill1); end
    endtask

    task automatic test_reset_mid_packet();
        m1.tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive1(32'h5000 + i, 4'hF, 1'b0, 1'b0);
            tick();
        end
        s1.tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (fill1 !== 5'd0) begin errors++; $display("FAIL mid_rst_fill: got %0d want 0", fill1); end
        checks++; if (s1.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", s1.tready); end
        checks++; if (m1.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", m1.tvalid); end
        checks++; if (pc1 !== 5'd0 || dp1 !== 1'b0) begin errors++; $display("FAIL mid_rst_cnt: got %0d/%b want 0/0", pc1, dp1); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (s1.tready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_rise: got %b want 1", s1.tready); end
        drive1(32'h6000, 4'hF, 1'b0, 1'b0);
        tick();
        drive1(32'h6001, 4'hF, 1'b1, 1'b0);
        tick();
        s1.tvalid = 1'b0;
        checks++; if (fill1 !== 5'd2) begin errors++; $display("FAIL mid_rst_new_fill: got %0d want 2", fill1); end
        m1.tready = 1'b1;
        checks++; if (m1.tdata !== 32'h6000 || m1.tlast !== 1'b0) begin errors++; $display("FAIL mid_rst_beat0: got %h/%b want 6000/0", m1.tdata, m1.tlast); end
        tick();
        checks++; if (m1.tdata !== 32'h6001 || m1.tlast !== 1'b1) begin errors++; $display("FAIL mid_rst_beat1: got %h/%b want 6001/1", m1.tdata, m1.tlast); end
        tick();
        m1.tready = 1'b0;
        checks++; if (m1.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_alone: got %b want 0", m1.tvalid); end
        checks++; if (pc1 !== 5'd0) begin errors++; $display("FAIL mid_rst_cnt_end: got %0d want 0", pc1); end
    endtask

    initial begin
        test_reset();
        test_pkt4();
        test_cut_through();
        test_exact_depth_full();
        test_oversize_drop();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
